// File: rtl/clock_div_pkg.sv
// Shared types, defaults and configuration helpers for the programmable clock divider.
// Clamp helpers work on a wide fixed width so that any WIDTH up to CLAMP_W can reuse them.
package clock_div_pkg;

  localparam int CLAMP_W  = 64;
  localparam int DEF_WIDTH = 28;
  localparam int DEF_DIV   = 50000000;
  localparam int DEF_HIGH  = 25000000;

  // Per-edge action of one channel, in priority order (STOP highest).
  typedef enum logic [1:0] {
    ACT_COUNT   = 2'd0,
    ACT_WRAP    = 2'd1,
    ACT_RESTART = 2'd2,
    ACT_STOP    = 2'd3
  } chan_act_e;

  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] d);
    return (d < CLAMP_W'(2)) ? CLAMP_W'(2) : d;
  endfunction

  // High time is bounded by the requested (unclamped) period.
  function automatic logic [CLAMP_W-1:0] clamp_high(input logic [CLAMP_W-1:0] d,
                                                    input logic [CLAMP_W-1:0] h);
    return (h > d) ? d : h;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active/shadow configuration, registered clock and tick.
// Shadow configuration is copied to active only at stop, restart or period wrap.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_sync_restart,
  input  logic             i_cfg_we,
  input  logic [WIDTH-1:0] i_cfg_div,
  input  logic [WIDTH-1:0] i_cfg_high,
  output logic             o_clock,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_sh_div;
  logic [WIDTH-1:0] r_sh_high;
  logic             r_pending;
  logic             r_clock;
  logic             r_tick;

  chan_act_e        w_act;
  logic             w_apply;
  logic [WIDTH-1:0] w_eff_high;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_clock_nxt;
  logic             w_tick_nxt;

  always_comb begin
    w_act = ACT_COUNT;
    if (!i_enable) begin
      w_act = ACT_STOP;
    end else if (i_sync_restart) begin
      w_act = ACT_RESTART;
    end else if (r_cnt >= r_div - ONE) begin
      // >= keeps an out-of-range count from running away after a shrink.
      w_act = ACT_WRAP;
    end

    w_apply    = r_pending && (w_act != ACT_COUNT);
    w_eff_high = w_apply ? r_sh_high : r_high;

    w_cnt_nxt   = '0;
    w_clock_nxt = 1'b0;
    w_tick_nxt  = 1'b0;
    case (w_act)
      ACT_STOP: begin
        w_cnt_nxt = '0;
      end
      ACT_RESTART: begin
        // Phase 0 of the configuration that governs from here on.
        w_clock_nxt = (w_eff_high != '0);
      end
      ACT_WRAP: begin
        w_clock_nxt = (r_cnt < r_high);
        w_tick_nxt  = 1'b1;
      end
      default: begin
        w_clock_nxt = (r_cnt < r_high);
        w_cnt_nxt   = r_cnt + ONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div     <= RST_DIV;
      r_high    <= RST_HIGH;
      r_sh_div  <= RST_DIV;
      r_sh_high <= RST_HIGH;
      r_pending <= 1'b0;
      r_clock   <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_clock <= w_clock_nxt;
      r_tick  <= w_tick_nxt;
      if (w_apply) begin
        r_div     <= r_sh_div;
        r_high    <= r_sh_high;
        r_pending <= 1'b0;
      end else if (i_cfg_we) begin
        r_pending <= 1'b1;
      end
      if (i_cfg_we) begin
        r_sh_div  <= i_cfg_div;
        r_sh_high <= i_cfg_high;
      end
    end
  end

  assign o_clock   = r_clock;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider / tick generator with a valid/ready config port.
// Top level decodes the handshake, clamps the request and fans it out to the channels.
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CHANNELS     = 2,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          sync_restart,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]              cfg_div,
  input  logic [WIDTH-1:0]              cfg_high,
  output logic [CHANNELS-1:0]           clock_out,
  output logic [CHANNELS-1:0]           tick
);

  // Handshake: a transfer happens on a clock edge where cfg_valid && cfg_ready.
  // cfg_ready is combinational on cfg_chan: low while that channel holds an
  // unapplied config, always high for a channel index that does not exist
  // (such transfers are accepted and dropped).

  logic [31:0]         w_chan_ext;
  logic [WIDTH-1:0]    w_div_cl;
  logic [WIDTH-1:0]    w_high_cl;
  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_we;
  logic                w_ready;
  logic                w_accept;

  assign w_chan_ext = 32'(cfg_chan);
  assign w_div_cl   = WIDTH'(clamp_div(CLAMP_W'(cfg_div)));
  assign w_high_cl  = WIDTH'(clamp_high(CLAMP_W'(cfg_div), CLAMP_W'(cfg_high)));

  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_chan_ext == 32'(i)) begin
        w_ready = !w_pending[i];
      end
    end
  end

  assign cfg_ready = w_ready;
  assign w_accept  = cfg_valid && w_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_we[g] = w_accept && (w_chan_ext == 32'(g));

    clock_div_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_chan (
      .clk            (clock_in),
      .rst_n          (reset_n),
      .i_enable       (enable[g]),
      .i_sync_restart (sync_restart),
      .i_cfg_we       (w_we[g]),
      .i_cfg_div      (w_div_cl),
      .i_cfg_high     (w_high_cl),
      .o_clock        (clock_out[g]),
      .o_tick         (tick[g]),
      .o_pending      (w_pending[g])
    );
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: randomized and directed stimulus against a
// period/phase reference model, scoreboarded per cycle on {cfg_ready, clock_out, tick}.
module tb_clock_div_prog;

  localparam int W  = 28;
  localparam int N  = 2;
  localparam int DD = 10;
  localparam int DH = 5;

  // Clock / reset
  logic         clock_in = 1'b0;
  logic         reset_n;
  logic [N-1:0] enable;
  logic         sync_restart;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [0:0]   cfg_chan;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic [N-1:0] clock_out;
  logic [N-1:0] tick;

  always #5 clock_in = ~clock_in;

  clock_div_prog #(
    .WIDTH        (W),
    .CHANNELS     (N),
    .DEFAULT_DIV  (DD),
    .DEFAULT_HIGH (DH)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .clock_out    (clock_out),
    .tick         (tick)
  );

  // Scoreboard
  logic [4:0] exp_q[$];
  logic [4:0] exp;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: position within the period, period length, high time, queued config.
  int         m_pos[N];
  int         m_div[N];
  int         m_high[N];
  int         m_sdiv[N];
  int         m_shigh[N];
  bit         m_pend[N];
  logic [N-1:0] m_clk;
  logic [N-1:0] m_tick;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_pos[c] = 0; m_div[c] = DD; m_high[c] = DH; m_pend[c] = 0;
      m_sdiv[c] = DD; m_shigh[c] = DH;
    end
    m_clk = '0;
    m_tick = '0;
  endtask

  function automatic bit model_ready();
    int ch;
    ch = int'(cfg_chan);
    if (ch >= N) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_edge();
    bit acc;
    bit boundary;
    int hi;
    acc = cfg_valid && model_ready();
    for (int c = 0; c < N; c++) begin
      boundary = 1'b0;
      if (!enable[c]) begin
        m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_pos[c] = 0; boundary = 1'b1;
      end else if (sync_restart) begin
        hi = m_pend[c] ? m_shigh[c] : m_high[c];
        m_clk[c] = (hi > 0); m_tick[c] = 1'b0; m_pos[c] = 0; boundary = 1'b1;
      end else if (m_pos[c] >= m_div[c] - 1) begin
        m_clk[c] = (m_pos[c] < m_high[c]); m_tick[c] = 1'b1; m_pos[c] = 0; boundary = 1'b1;
      end else begin
        m_clk[c] = (m_pos[c] < m_high[c]); m_tick[c] = 1'b0; m_pos[c] = m_pos[c] + 1;
      end
      if (boundary && m_pend[c]) begin
        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
      end
      if (acc && int'(cfg_chan) == c) begin
        m_sdiv[c]  = (cfg_div < 2) ? 2 : int'(cfg_div);
        m_shigh[c] = (cfg_high > cfg_div) ? int'(cfg_div) : int'(cfg_high);
        m_pend[c]  = 1;
      end
    end
  endtask

  // Driver: one clock, model updated on the same edge, expectation queued for the negedge sample.
  task automatic run_cycle();
    @(posedge clock_in);
    model_edge();
    @(negedge clock_in);
    exp_q.push_back({model_ready(), m_clk, m_tick});
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = '0; sync_restart = 1'b0; cfg_valid = 1'b0;
    cfg_chan = 1'b0; cfg_div = '0; cfg_high = '0;
    model_reset();
    #3;
    n_checks++;
    if ({cfg_ready, clock_out, tick} !== 5'b10000)
      $display("FAIL reset_ch0 got=%b exp=%b", {cfg_ready, clock_out, tick}, 5'b10000);
    else n_pass++;
    cfg_chan = 1'b1;
    #1;
    n_checks++;
    if ({cfg_ready, clock_out, tick} !== 5'b10000)
      $display("FAIL reset_ch1 got=%b exp=%b", {cfg_ready, clock_out, tick}, 5'b10000);
    else n_pass++;
    @(negedge clock_in);
    reset_n = 1'b1;
    cfg_chan = 1'b0;
    run_cycle();
    exp = exp_q.pop_front(); n_checks++;
    if ({cfg_ready, clock_out, tick} !== exp)
      $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
    else n_pass++;
  endtask

  task automatic test_default();
    int hi0, tk0;
    enable = 2'b11;
    hi0 = 0; tk0 = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle();
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL default cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
      if (i >= 10 && i < 20) begin
        hi0 += int'(clock_out[0]);
        tk0 += int'(tick[0]);
      end
    end
    n_checks++;
    if (hi0 !== 5) $display("FAIL default_duty got=%0d exp=%0d", hi0, 5);
    else n_pass++;
    n_checks++;
    if (tk0 !== 1) $display("FAIL default_ticks got=%0d exp=%0d", tk0, 1);
    else n_pass++;
  endtask

  task automatic test_reconfig();
    int guard;
    guard = 0;
    cfg_chan = 1'b0;
    while (m_pos[0] != 3 && guard < 20) begin
      run_cycle(); guard++;
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL reconfig_wait cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
    end
    n_checks++;
    if (m_pos[0] != 3) $display("FAIL reconfig_phase got=%0d exp=%0d", m_pos[0], 3);
    else n_pass++;
    cfg_valid = 1'b1; cfg_div = W'(4); cfg_high = W'(1);
    run_cycle();
    cfg_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL reconfig cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
      run_cycle();
    end
    exp = exp_q.pop_front(); n_checks++;
    if ({cfg_ready, clock_out, tick} !== exp)
      $display("FAIL reconfig_end cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
    else n_pass++;
  endtask

  task automatic test_enable();
    int guard, quiet;
    guard = 0;
    while (m_pos[1] != 6 && guard < 20) begin
      run_cycle(); guard++;
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL enable_wait cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
    end
    enable[1] = 1'b0;
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL enable_off cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
      quiet += int'(clock_out[1]) + int'(tick[1]);
    end
    n_checks++;
    if (quiet !== 0) $display("FAIL enable_quiet got=%0d exp=%0d", quiet, 0);
    else n_pass++;
    enable[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      run_cycle();
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL enable_on cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    logic [W-1:0] dv[2];
    logic [W-1:0] hv[2];
    int guard;
    dv[0] = W'(0); hv[0] = W'(0);
    dv[1] = W'(4); hv[1] = W'(7);
    cfg_chan = 1'b1;
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while (!model_ready() && guard < 20) begin
        run_cycle(); guard++;
        exp = exp_q.pop_front(); n_checks++;
        if ({cfg_ready, clock_out, tick} !== exp)
          $display("FAIL clamp_wait cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
        else n_pass++;
      end
      cfg_valid = 1'b1; cfg_div = dv[k]; cfg_high = hv[k];
      run_cycle();
      cfg_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        exp = exp_q.pop_front(); n_checks++;
        if ({cfg_ready, clock_out, tick} !== exp)
          $display("FAIL clamp%0d cyc=%0d got=%b exp=%b", k, cyc, {cfg_ready, clock_out, tick}, exp);
        else n_pass++;
        run_cycle();
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_sync_restart();
    sync_restart = 1'b1;
    run_cycle();
    sync_restart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL sync cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
      run_cycle();
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_chan     = 1'($urandom_range(0, 1));
      cfg_div      = W'($urandom_range(0, 12));
      cfg_high     = W'($urandom_range(0, 14));
      sync_restart = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) enable[$urandom_range(0, 1)] ^= 1'b1;
      run_cycle();
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
    end
    cfg_valid = 1'b0; sync_restart = 1'b0; enable = 2'b11;
    run_cycle();
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    int guard, tk0;
    guard = 0;
    cfg_chan = 1'b0;
    while (!model_ready() && guard < 20) begin
      run_cycle(); guard++;
      void'(exp_q.pop_front());
    end
    cfg_valid = 1'b1; cfg_div = W'(6); cfg_high = W'(2);
    run_cycle();
    cfg_valid = 1'b0;
    run_cycle();
    exp = exp_q.pop_front(); exp = exp_q.pop_front(); n_checks++;
    if ({cfg_ready, clock_out, tick} !== exp)
      $display("FAIL rstmid_pend cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_ready, clock_out, tick} !== 5'b10000)
      $display("FAIL rstmid_async got=%b exp=%b", {cfg_ready, clock_out, tick}, 5'b10000);
    else n_pass++;
    model_reset();
    exp_q.delete();
    @(negedge clock_in);
    reset_n = 1'b1;
    tk0 = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      exp = exp_q.pop_front(); n_checks++;
      if ({cfg_ready, clock_out, tick} !== exp)
        $display("FAIL rstmid cyc=%0d got=%b exp=%b", cyc, {cfg_ready, clock_out, tick}, exp);
      else n_pass++;
      tk0 += int'(tick[0]);
    end
    n_checks++;
    if (tk0 !== 2) $display("FAIL rstmid_period got=%0d exp=%0d", tk0, 2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_reconfig();
    test_enable();
    test_clamp();
    test_sync_restart();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
